deserializer_out: RTL and testbench

DESERIALIZER_OUT -- requirements
Module: deserializer_out

---
 rtl/serdes_pkg.sv | 20 ++
 rtl/rx_serial.sv | 36 +++
 rtl/deserializer_out.sv | 148 ++++++++++++++
 tb/tb_deserializer_out.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared serdes constants and state encoding, used by both the receive and
// transmit sides of the link.
package serdes_pkg;

  localparam int unsigned SYM_W = 9;
  localparam logic [7:0] COMMA = 8'h3C;
  localparam logic KCODE = 1'b1;
  localparam logic [SYM_W-1:0] COMMA_SYM = {KCODE, COMMA};

  // Receive framer states; plain constants keep the encoding legacy-friendly.
  typedef logic [1:0] state_t;
  localparam state_t ST_HUNT   = 2'd0;
  localparam state_t ST_CHECK  = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;

  function automatic logic is_comma(input logic [SYM_W-1:0] sym);
    return sym == COMMA_SYM;
  endfunction

endpackage

// File: rtl/rx_serial.sv
// Serial front end: 9-bit shift register plus bit counter that marks word
// boundaries once the framer has chosen an alignment.
module rx_serial
  import serdes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             align,    // restart bit counting at this bit
  input  logic             count,    // advance the bit counter
  output logic [SYM_W-1:0] word,     // last nine bits including din
  output logic             boundary  // word holds a complete aligned symbol
);

  logic [SYM_W-1:0] shift_q;
  logic [3:0]       bit_cnt_q;

  assign word     = {shift_q[SYM_W-2:0], din};
  assign boundary = count && (bit_cnt_q == 4'd8);

  // Shift every cycle; count 0..8 and wrap once aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q <= word;
      if (align) begin
        bit_cnt_q <= '0;
      end else if (count) begin
        bit_cnt_q <= (bit_cnt_q == 4'd8) ? 4'd0 : bit_cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/deserializer_out.sv
// Receive framer: hunts for a comma, confirms alignment, then assembles
// three-byte frames delimited by commas and flags framing errors.
module deserializer_out
  import serdes_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_i,
  output logic [23:0] data_o,
  output logic        valid_o,
  output logic        lock_o,
  output logic        err_o
);

  localparam logic [2:0] LOCK_TGT = 3'(LOCK_CNT);

  state_t           state_q, state_d;
  logic [2:0]       comma_cnt_q, comma_cnt_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       byte0_q, byte0_d;
  logic [7:0]       byte1_q, byte1_d;
  logic [23:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             lock_q;
  logic [SYM_W-1:0] word;
  logic             boundary;
  logic             align;
  logic             frame_err;

  rx_serial u_rx_serial (
    .clk      (clk_i),
    .rst      (rst_i),
    .din      (data_i),
    .align    (align),
    .count    (state_q != ST_HUNT),
    .word     (word),
    .boundary (boundary)
  );

  // Framer next state, byte assembly and output pulses.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    byte_idx_d  = byte_idx_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    align       = 1'b0;
    frame_err   = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (is_comma(word)) begin
          align       = 1'b1;
          comma_cnt_d = 3'd1;
          byte_idx_d  = 2'd0;
          state_d     = (LOCK_CNT == 1) ? ST_LOCKED : ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (boundary) begin
          if (is_comma(word)) begin
            comma_cnt_d = comma_cnt_q + 3'd1;
            if (comma_cnt_q + 3'd1 == LOCK_TGT) begin
              state_d    = ST_LOCKED;
              byte_idx_d = 2'd0;
            end
          end else begin
            // Misaligned guess: silently resume hunting.
            state_d = ST_HUNT;
          end
        end
      end
      ST_LOCKED: begin
        if (boundary) begin
          if (is_comma(word)) begin
            if (byte_idx_q == 2'd1 || byte_idx_q == 2'd2) begin
              frame_err = 1'b1;
            end else begin
              byte_idx_d = 2'd0;
            end
          end else if (word[SYM_W-1] != KCODE) begin
            case (byte_idx_q)
              2'd0: begin
                byte0_d    = word[7:0];
                byte_idx_d = 2'd1;
              end
              2'd1: begin
                byte1_d    = word[7:0];
                byte_idx_d = 2'd2;
              end
              2'd2: begin
                data_d     = {word[7:0], byte1_q, byte0_q};
                valid_d    = 1'b1;
                byte_idx_d = 2'd3;
              end
              default: frame_err = 1'b1;  // data where a comma was due
            endcase
          end else begin
            frame_err = 1'b1;  // unknown control symbol
          end
          if (frame_err) begin
            err_d      = 1'b1;
            state_d    = ST_HUNT;
            byte_idx_d = 2'd0;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // All state and outputs registered; lock mirrors the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_HUNT;
      comma_cnt_q <= '0;
      byte_idx_q  <= '0;
      byte0_q     <= '0;
      byte1_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      byte_idx_q  <= byte_idx_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      lock_q      <= (state_d == ST_LOCKED);
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign lock_o  = lock_q;

endmodule

// File: tb/tb_deserializer_out.sv
// Bench for deserializer_out: symbol-level reference model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_deserializer_out;

  localparam int LOCK = 2;
  localparam logic [8:0] K_COMMA = 9'h13C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic [23:0] dout;
  logic        valid;
  logic        lock;
  logic        err;

  always #5 clk = ~clk;

  deserializer_out #(.LOCK_CNT(LOCK)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (din),
    .data_o  (dout),
    .valid_o (valid),
    .lock_o  (lock),
    .err_o   (err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int valid_seen = 0;
  int err_seen   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: works on whole symbols, tracking alignment as the
  // number of bits seen since the comma that was found.
  logic [8:0]  m_hist;
  int          m_mode;   // 0 searching, 1 confirming, 2 framed
  int          m_since;
  int          m_commas;
  logic [7:0]  m_bytes[$];
  logic [23:0] m_data;
  logic        m_valid, m_err, m_lock;

  task automatic model_reset();
    m_hist = '0; m_mode = 0; m_since = 0; m_commas = 0;
    m_bytes.delete();
    m_data = '0; m_valid = 0; m_err = 0; m_lock = 0;
  endtask

  task automatic model_step(input logic b);
    logic [8:0] w;
    bit bad;
    w = {m_hist[7:0], b};
    m_hist = w;
    m_valid = 0; m_err = 0; bad = 0;
    if (m_mode == 0) begin
      if (w == K_COMMA) begin
        m_since = 0; m_commas = 1; m_bytes.delete();
        m_mode = (LOCK == 1) ? 2 : 1;
      end
    end else begin
      m_since++;
      if (m_since % 9 == 0) begin
        if (m_mode == 1) begin
          if (w == K_COMMA) begin
            m_commas++;
            if (m_commas == LOCK) begin m_mode = 2; m_bytes.delete(); end
          end else m_mode = 0;
        end else begin
          if (w == K_COMMA) begin
            if (m_bytes.size() == 1 || m_bytes.size() == 2) bad = 1;
            else m_bytes.delete();
          end else if (!w[8]) begin
            if (m_bytes.size() == 3) bad = 1;
            else begin
              m_bytes.push_back(w[7:0]);
              if (m_bytes.size() == 3) begin
                m_data = {m_bytes[2], m_bytes[1], m_bytes[0]};
                m_valid = 1;
              end
            end
          end else bad = 1;
          if (bad) begin m_err = 1; m_mode = 0; m_bytes.delete(); end
        end
      end
    end
    m_lock = (m_mode == 2);
  endtask

  // Compare process: advance the model on each edge, check just after it.
  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step(din);
    #1;
    chk("data_o", dout, m_data);
    chk("valid_o", valid, m_valid);
    chk("err_o", err, m_err);
    chk("lock_o", lock, m_lock);
    chk("valid_err_excl", valid & err, 0);
    if (valid) valid_seen++;
    if (err) err_seen++;
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
  endtask

  task automatic send_sym(input logic [8:0] s);
    for (int i = 8; i >= 0; i--) send_bit(s[i]);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    valid_seen = 0;
    err_seen = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset data", dout, 24'h0);
    chk("reset lock", lock, 0);
    chk("reset valid", valid, 0);
    rst = 1'b0;

    // Aligned lock and one frame
    clear_counts();
    send_sym(K_COMMA);
    settle();
    chk("s1 no lock after 1 comma", lock, 0);
    send_sym(K_COMMA);
    settle();
    chk("s1 lock after 2 commas", lock, 1);
    send_sym(K_COMMA);
    send_sym(9'h0A1); send_sym(9'h0B2); send_sym(9'h0C3);
    send_sym(K_COMMA);
    settle();
    chk("s1 data", dout, 24'hC3B2A1);
    chk("s1 valid count", valid_seen, 1);
    chk("s1 err count", err_seen, 0);

    // Misaligned start after reset
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s2 async reset data", dout, 24'h0);
    chk("s2 async reset lock", lock, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_sym(K_COMMA); send_sym(K_COMMA);
    send_sym(9'h011); send_sym(9'h022); send_sym(9'h033);
    send_sym(K_COMMA);
    settle();
    chk("s2 data", dout, 24'h332211);
    chk("s2 valid count", valid_seen, 1);
    chk("s2 lock", lock, 1);

    // Short frame
    clear_counts();
    send_sym(K_COMMA); send_sym(9'h055); send_sym(K_COMMA);
    settle();
    chk("s3 err count", err_seen, 1);
    chk("s3 lock dropped", lock, 0);
    chk("s3 data kept", dout, 24'h332211);
    chk("s3 valid count", valid_seen, 0);

    // Missing comma after a full frame
    clear_counts();
    send_sym(K_COMMA); send_sym(K_COMMA);
    send_sym(9'h001); send_sym(9'h002); send_sym(9'h003); send_sym(9'h004);
    settle();
    chk("s4 valid count", valid_seen, 1);
    chk("s4 data", dout, 24'h030201);
    chk("s4 err count", err_seen, 1);
    chk("s4 lock dropped", lock, 0);

    // Unknown control symbol
    clear_counts();
    send_sym(K_COMMA); send_sym(K_COMMA);
    send_sym(9'h1BC);
    settle();
    chk("s5 err count", err_seen, 1);
    chk("s5 lock dropped", lock, 0);
    chk("s5 data kept", dout, 24'h030201);

    // Reset mid-frame, then a clean frame
    clear_counts();
    send_sym(K_COMMA); send_sym(K_COMMA);
    send_sym(9'h0A1); send_sym(9'h0B2);
    settle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s6 reset data", dout, 24'h0);
    chk("s6 reset lock", lock, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("s6 no pulse in reset", valid_seen + err_seen, 0);
    send_sym(K_COMMA); send_sym(K_COMMA);
    send_sym(9'h0D4); send_sym(9'h0E5); send_sym(9'h0F6);
    send_sym(K_COMMA);
    settle();
    chk("s6 valid count", valid_seen, 1);
    chk("s6 err count", err_seen, 0);
    chk("s6 data", dout, 24'hF6E5D4);
    chk("s6 lock", lock, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
